// File: rtl/sensor_distancia_pkg.sv
// Shared types and constants for the ultrasonic range sensor controller.
package sensor_distancia_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    ESPERA,
    MIDE,
    PAUSA
  } estado_t;

  localparam int unsigned DIST_W = 9;
  localparam logic [DIST_W-1:0] DIST_MAX = 9'd511;
  localparam int unsigned CNT_W = 16;

  localparam int unsigned TICKS_US_DEF   = 50;
  localparam int unsigned TRIG_US_DEF    = 10;
  localparam int unsigned US_POR_CM_DEF  = 58;
  localparam int unsigned TIMEOUT_US_DEF = 30000;
  localparam int unsigned PERIODO_US_DEF = 60000;

  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
    return (v == DIST_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sensor_distancia_if.sv
// Sensor pins, range result and FSM debug state of the distance sensor block.
interface sensor_distancia_if;
  import sensor_distancia_pkg::*;

  // valido is a one-cycle strobe with no back-pressure: whoever consumes
  // distancia/sin_eco must take them in the cycle valido is high; both stay
  // stable until the next strobe.
  logic                habilitar;
  logic                echo;
  logic                trig;
  logic [DIST_W-1:0]   distancia;
  logic                valido;
  logic                sin_eco;
  estado_t             estado;

  modport master (
    output habilitar, echo,
    input  trig, distancia, valido, sin_eco, estado
  );

  modport slave (
    input  habilitar, echo,
    output trig, distancia, valido, sin_eco, estado
  );

endinterface

// File: rtl/sensor_distancia_tick_us.sv
// Free-running microsecond prescaler; clr holds it at zero so the first tick
// after release lands exactly TICKS cycles later.
module tick_us #(
  parameter int unsigned TICKS = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == W'(TICKS - 1)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == W'(TICKS - 1));

endmodule

// File: rtl/sensor_distancia.sv
// Ultrasonic range controller: periodic trigger, echo-width measurement in cm,
// timeout handling, result strobe.
module sensor_distancia
  import sensor_distancia_pkg::*;
#(
  parameter int unsigned TICKS_US   = TICKS_US_DEF,
  parameter int unsigned TRIG_US    = TRIG_US_DEF,
  parameter int unsigned US_POR_CM  = US_POR_CM_DEF,
  parameter int unsigned TIMEOUT_US = TIMEOUT_US_DEF,
  parameter int unsigned PERIODO_US = PERIODO_US_DEF
) (
  input  logic clk,
  input  logic rst,
  sensor_distancia_if.slave sd
);

  logic              echo_s1_q, echo_s2_q, echo_s3_q;
  logic              echo_sube, echo_baja;
  logic              tick, arranque;
  estado_t           state_q;
  logic              trig_q, valido_q, sin_eco_q;
  logic [DIST_W-1:0] dist_q, cm_q, cm_d;
  logic [CNT_W-1:0]  us_q, us_d, per_q, per_d, sub_q, sub_d;
  logic              fin_trig, fin_timeout, fin_periodo, fin_cm;

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_s3_q <= 1'b0;
    end else begin
      echo_s1_q <= sd.echo;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
    end
  end

  assign echo_sube = echo_s2_q & ~echo_s3_q;
  assign echo_baja = ~echo_s2_q & echo_s3_q;

  // The prescaler is also realigned when PAUSA hands over to TRIG, so every
  // trigger pulse starts on a fresh microsecond boundary.
  assign arranque = (state_q == IDLE) || (state_q == PAUSA && fin_periodo);

  tick_us #(.TICKS(TICKS_US)) u_tick_us (
    .clk  (clk),
    .rst  (rst),
    .clr  (arranque),
    .tick (tick)
  );

  // cm_d already includes this cycle's tick, so the echo edge cycle is counted.
  always_comb begin
    us_d        = tick ? us_q + 1'b1 : us_q;
    per_d       = (tick && per_q < CNT_W'(PERIODO_US)) ? per_q + 1'b1 : per_q;
    fin_trig    = tick && (us_q == CNT_W'(TRIG_US - 1));
    fin_timeout = tick && (us_q == CNT_W'(TIMEOUT_US - 1));
    fin_periodo = (per_d >= CNT_W'(PERIODO_US));
    fin_cm      = tick && (sub_q == CNT_W'(US_POR_CM - 1));
    sub_d       = fin_cm ? '0 : (tick ? sub_q + 1'b1 : sub_q);
    cm_d        = fin_cm ? sat_inc(cm_q) : cm_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      trig_q    <= 1'b0;
      valido_q  <= 1'b0;
      sin_eco_q <= 1'b0;
      dist_q    <= '0;
      cm_q      <= '0;
      us_q      <= '0;
      per_q     <= '0;
      sub_q     <= '0;
    end else begin
      valido_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sd.habilitar) begin
            state_q <= TRIG;
            trig_q  <= 1'b1;
            us_q    <= '0;
            per_q   <= '0;
          end
        end
        TRIG: begin
          per_q <= per_d;
          us_q  <= us_d;
          if (fin_trig) begin
            state_q <= ESPERA;
            trig_q  <= 1'b0;
            us_q    <= '0;
          end
        end
        ESPERA: begin
          per_q <= per_d;
          us_q  <= us_d;
          if (fin_timeout) begin
            state_q   <= PAUSA;
            dist_q    <= DIST_MAX;
            sin_eco_q <= 1'b1;
            valido_q  <= 1'b1;
          end else if (echo_sube) begin
            state_q <= MIDE;
            us_q    <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
          end
        end
        MIDE: begin
          per_q <= per_d;
          us_q  <= us_d;
          sub_q <= sub_d;
          cm_q  <= cm_d;
          if (fin_timeout) begin
            state_q   <= PAUSA;
            dist_q    <= DIST_MAX;
            sin_eco_q <= 1'b1;
            valido_q  <= 1'b1;
          end else if (echo_baja) begin
            state_q   <= PAUSA;
            dist_q    <= cm_d;
            sin_eco_q <= 1'b0;
            valido_q  <= 1'b1;
          end
        end
        PAUSA: begin
          per_q <= per_d;
          if (fin_periodo) begin
            if (sd.habilitar) begin
              state_q <= TRIG;
              trig_q  <= 1'b1;
              us_q    <= '0;
              per_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sd.trig      = trig_q;
  assign sd.distancia = dist_q;
  assign sd.valido    = valido_q;
  assign sd.sin_eco   = sin_eco_q;
  assign sd.estado    = state_q;

endmodule
